// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch request/response handshake between instr_fetch and the memory controller
interface instr_fetch_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, single-outstanding fetch FSM and instruction queue feeding the decoder
module instr_fetch #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  instr_fetch_if.master       mem,
  input  logic                rs_full,
  input  logic                lsb_full,
  input  logic                rob_full,
  input  logic                rob_flush,
  input  logic [31:0]         rob_target_pc,
  output logic                IF_success,
  output logic [31:0]         instr,
  output logic [31:0]         fetch_pc
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   q_data [QUEUE_DEPTH];
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   pc;

  logic        issue, push, pop, stall, take_resp;
  logic        is_jal;
  logic [31:0] jal_imm;

  assign stall     = rs_full | lsb_full | rob_full;
  assign pop       = !stall && (count != '0) && !rob_flush;
  assign take_resp = (state != IDLE) && mem.mem_resp_valid;
  assign is_jal    = (mem.mem_resp_data[6:0] == 7'b1101111);
  assign jal_imm   = {{12{mem.mem_resp_data[31]}}, mem.mem_resp_data[19:12],
                      mem.mem_resp_data[20], mem.mem_resp_data[30:21], 1'b0};

  // In IDLE nothing is in flight, so a free queue slot is reserved for the response.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!rob_flush && (count < CW'(QUEUE_DEPTH))) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_resp_valid) begin
          push       = !rob_flush;
          state_next = IDLE;
        end else if (rob_flush) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (mem.mem_resp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (rdy) state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_addr  <= 32'h0;
      IF_success        <= 1'b0;
      instr             <= 32'h0;
      fetch_pc          <= 32'h0;
    end else if (!rdy) begin
      IF_success <= 1'b0;
    end else begin
      if (issue) begin
        mem.mem_req_valid <= 1'b1;
        mem.mem_req_addr  <= pc;
      end else if (take_resp) begin
        mem.mem_req_valid <= 1'b0;
      end

      if (rob_flush) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        IF_success <= 1'b0;
        pc         <= rob_target_pc;
      end else begin
        IF_success <= pop;
        if (pop) begin
          instr    <= q_data[head];
          fetch_pc <= q_pc[head];
          head     <= head + 1'b1;
        end
        if (push) begin
          q_data[tail] <= mem.mem_resp_data;
          q_pc[tail]   <= pc;
          tail         <= tail + 1'b1;
          pc           <= is_jal ? pc + jal_imm : pc + 32'd4;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed bench for instr_fetch against a queue-based reference model
module tb_instr_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1;
  logic        rs_full = 1'b0, lsb_full = 1'b0, rob_full = 1'b0, rob_flush = 1'b0;
  logic [31:0] rob_target_pc = 32'h0;
  logic        if_succ;
  logic [31:0] instr, fetch_pc;

  instr_fetch_if mif ();

  instr_fetch #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .mem          (mif),
    .rs_full      (rs_full),
    .lsb_full     (lsb_full),
    .rob_full     (rob_full),
    .rob_flush    (rob_flush),
    .rob_target_pc(rob_target_pc),
    .IF_success   (if_succ),
    .instr        (instr),
    .fetch_pc     (fetch_pc)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory contents; mode selects the directed images
  int mode = 1;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    case (mode)
      2: return (a == 32'h100) ? 32'h020000EF : (a == 32'h120) ? 32'hFE1FF06F : 32'h13;
      3: return (a == 32'h0) ? 32'hDEADBEEF : 32'h13;
      1: return 32'h13;
      default: begin
        h = (a * 32'h9E3779B1) ^ 32'h5BD1E995;
        h = h ^ (h >> 15);
        if (h[27:24] == 4'h0) h[6:0] = 7'h6F;
        return h;
      end
    endcase
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [31:0] d);
    int off;
    if (d[6:0] != 7'h6F) return p + 32'd4;
    off = $signed({d[31], d[19:12], d[20], d[30:21]}) * 2;
    return p + off;
  endfunction

  // reference model: queue of {word, pc}, a pending-request flag and a drop-on-arrival flag
  logic [63:0] mq[$];
  logic [63:0] e;
  int          n;
  logic [31:0] m_pc, m_req_a, m_instr, m_fpc;
  bit          m_busy, m_disc, m_req_v, m_succ;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_pc = 0; m_busy = 0; m_disc = 0; m_req_v = 0; m_req_a = 0;
      m_succ = 0; m_instr = 0; m_fpc = 0;
    end else if (!rdy) begin
      m_succ = 0;
    end else begin
      n = mq.size();
      if (rob_flush) begin
        mq.delete();
        m_succ = 0;
        if (m_busy && mif.mem_resp_valid) begin
          m_busy = 0; m_disc = 0; m_req_v = 0;
        end else if (m_busy) begin
          m_disc = 1;
        end
        m_pc = rob_target_pc;
      end else begin
        m_succ = 0;
        if (!(rs_full || lsb_full || rob_full) && n > 0) begin
          e = mq.pop_front();
          m_succ = 1; m_instr = e[63:32]; m_fpc = e[31:0];
        end
        if (m_busy && mif.mem_resp_valid) begin
          m_busy = 0; m_req_v = 0;
          if (!m_disc) begin
            mq.push_back({mif.mem_resp_data, m_pc});
            m_pc = next_pc(m_pc, mif.mem_resp_data);
          end
          m_disc = 0;
        end else if (!m_busy && n < DEPTH) begin
          m_busy = 1; m_req_v = 1; m_req_a = m_pc;
        end
      end
    end
  end

  logic [31:0] req_log[$], succ_pc[$], succ_instr[$];
  int          succ_cyc[$], resp_log[$];
  bit          prev_req = 0, saw_dead = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("if_success", 32'(if_succ), 32'(m_succ));
      chk("instr", instr, m_instr);
      chk("fetch_pc", fetch_pc, m_fpc);
      chk("mem_req_valid", 32'(mif.mem_req_valid), 32'(m_req_v));
      chk("mem_req_addr", mif.mem_req_addr, m_req_a);
      if (if_succ) begin
        succ_cyc.push_back(cyc); succ_pc.push_back(fetch_pc); succ_instr.push_back(instr);
      end
      if (mif.mem_req_valid && !prev_req) req_log.push_back(mif.mem_req_addr);
      if (instr == 32'hDEADBEEF) saw_dead = 1;
    end
    prev_req = mif.mem_req_valid;
  end

  // memory responder: latency counted in rdy-high cycles of a visible request
  int lat = 3, cnt = 0;
  bit responded = 0, flush_on_resp = 0, fired = 0;

  task automatic step();
    mif.mem_resp_valid = 1'b0;
    if (rst || !mif.mem_req_valid) begin
      responded = 0;
      cnt = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
    end else if (!responded && rdy) begin
      if (cnt <= 1) begin
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_data  = mem_word(mif.mem_req_addr);
        responded = 1;
        resp_log.push_back(cyc);
        if (flush_on_resp) begin
          rob_flush = 1; rob_target_pc = 32'h200;
          rob_full = 0; rs_full = 0; lsb_full = 0;
          flush_on_resp = 0; fired = 1;
        end
      end else begin
        cnt--;
      end
    end
    @(negedge clk);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
    req_log.delete(); succ_pc.delete(); succ_instr.delete(); succ_cyc.delete(); resp_log.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(mif.mem_req_valid), 32'h0);
    chk({tag, "_req_addr"}, mif.mem_req_addr, 32'h0);
    chk({tag, "_if_success"}, 32'(if_succ), 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_fetch_pc"}, fetch_pc, 32'h0);
  endtask

  int          idx_req, idx_succ, w;
  logic [31:0] hold_addr;

  initial begin
    mif.mem_resp_valid = 1'b0;
    mif.mem_resp_data  = 32'h0;
    @(negedge clk);

    // first fetch with 3-cycle memory
    mode = 1; lat = 3;
    do_reset();
    cmp_en = 1;
    chk_reset_outputs("reset");
    steps(30);
    chk("t1_first_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFFFFFF, 32'h0);
    chk("t1_second_req", (req_log.size() > 1) ? req_log[1] : 32'hFFFFFFFF, 32'h4);
    chk("t1_latency", (succ_cyc.size() > 0 && resp_log.size() > 0) ? 32'(succ_cyc[0] - resp_log[0]) : 32'hFFFFFFFF, 32'd2);
    chk("t1_fetch_pc", (succ_pc.size() > 0) ? succ_pc[0] : 32'hFFFFFFFF, 32'h0);
    chk("t1_instr", (succ_instr.size() > 0) ? succ_instr[0] : 32'hFFFFFFFF, 32'h13);

    // JAL forward and backward
    mode = 2; lat = 2;
    do_reset();
    rob_flush = 1; rob_target_pc = 32'h100; step(); rob_flush = 0;
    steps(40);
    chk("t2_req0", (req_log.size() > 0) ? req_log[0] : 32'hFFFFFFFF, 32'h100);
    chk("t2_req1", (req_log.size() > 1) ? req_log[1] : 32'hFFFFFFFF, 32'h120);
    chk("t2_req2", (req_log.size() > 2) ? req_log[2] : 32'hFFFFFFFF, 32'h100);

    // back-pressure fills the queue
    mode = 1; lat = 1; rob_full = 1;
    do_reset();
    steps(14);
    chk("t3_no_issue", 32'(succ_pc.size()), 32'd0);
    chk("t3_req_idle", 32'(mif.mem_req_valid), 32'h0);
    chk("t3_req_count", 32'(req_log.size()), 32'd4);
    rob_full = 0;
    steps(8);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_pc%0d", i), (succ_pc.size() > i) ? succ_pc[i] : 32'hFFFFFFFF, 32'(4 * i));
    chk("t3_back_to_back", (succ_cyc.size() > 3) ? 32'(succ_cyc[3] - succ_cyc[0]) : 32'hFFFFFFFF, 32'd3);

    // flush while waiting; the late response is dropped
    mode = 3; lat = 3; saw_dead = 0;
    do_reset();
    w = 0;
    while (!mif.mem_req_valid && w < 10) begin step(); w++; end
    chk("t4_req_seen", 32'(mif.mem_req_valid), 32'h1);
    rob_flush = 1; rob_target_pc = 32'h200; step(); rob_flush = 0;
    steps(20);
    chk("t4_no_deadbeef", 32'(saw_dead), 32'h0);
    chk("t4_next_req", (req_log.size() > 1) ? req_log[1] : 32'hFFFFFFFF, 32'h200);
    chk("t4_first_pc", (succ_pc.size() > 0) ? succ_pc[0] : 32'hFFFFFFFF, 32'h200);

    // flush coincident with a response and a pending pop
    mode = 1; lat = 3; rob_full = 1;
    do_reset();
    w = 0;
    while (resp_log.size() < 2 && w < 30) begin step(); w++; end
    idx_succ = succ_pc.size();
    flush_on_resp = 1; fired = 0;
    w = 0;
    while (!fired && w < 30) begin step(); w++; end
    rob_flush = 0;
    chk("t5_fired", 32'(fired), 32'h1);
    chk("t5_no_success", 32'(if_succ), 32'h0);
    idx_req = req_log.size();
    steps(20);
    chk("t5_next_req", (req_log.size() > idx_req) ? req_log[idx_req] : 32'hFFFFFFFF, 32'h200);
    chk("t5_first_pc", (succ_pc.size() > idx_succ) ? succ_pc[idx_succ] : 32'hFFFFFFFF, 32'h200);

    // rdy low mid-wait, then reset mid-wait
    mode = 1; lat = 4; rob_full = 1;
    do_reset();
    w = 0;
    while (resp_log.size() < 2 && w < 40) begin step(); w++; end
    w = 0;
    while (!mif.mem_req_valid && w < 10) begin step(); w++; end
    chk("t6_in_wait", 32'(mif.mem_req_valid), 32'h1);
    hold_addr = mif.mem_req_addr;
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_addr_hold", mif.mem_req_addr, hold_addr);
      chk("t6_success_low", 32'(if_succ), 32'h0);
    end
    rdy = 1;
    steps(10);
    w = 0;
    while (!mif.mem_req_valid && w < 10) begin step(); w++; end
    do_reset();
    chk_reset_outputs("t6_rst");
    rob_full = 0;

    // randomized traffic
    mode = 0; lat = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      rs_full       = ($urandom_range(0, 5) == 0);
      lsb_full      = ($urandom_range(0, 7) == 0);
      rob_full      = ($urandom_range(0, 5) == 0);
      rob_flush     = ($urandom_range(0, 29) == 0);
      rob_target_pc = $urandom & 32'hFFFFFFFC;
      rst           = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0; rob_flush = 0; rdy = 1;
    steps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
